// File: rtl/karp_defs.sv
// Shared fetch-path encodings used by fetch_unit, program_counter and the decoder.
package karp_defs;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_LATCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Fetch sequencer: read at pc, latch word, present to decode (one word per 3 cycles, held while ir_ready=0).
// Optional FETCH_COUNT_EN adds a saturating accepted-instruction counter; otherwise fetch_count is tied to 0.
module fetch_unit
  import karp_defs::*;
#(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  pc,
  output logic [1:0]         pc_ctrl,
  output logic [ADDR_W-1:0]  pc_load,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  logic               accept;

  assign mem_addr = pc;
  assign accept   = ir_valid_q && ir_ready;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_ctrl    = PC_HOLD;
    pc_load    = '0;
    mem_rd_en  = 1'b0;

    if (clr) begin
      state_d    = S_FETCH;
      ir_valid_d = 1'b0;
    end else if (halt) begin
      // halt freezes the PC and beats any branch in the same cycle
      state_d    = S_HALT;
      ir_valid_d = 1'b0;
    end else if (branch_req && state_q != S_HALT) begin
      pc_ctrl    = PC_LOAD;
      pc_load    = branch_target;
      state_d    = S_FETCH;
      ir_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_rd_en = 1'b1;
          state_d   = S_LATCH;
        end
        S_LATCH: begin
          pc_ctrl    = PC_INC;
          ir_d       = mem_data;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          state_d    = S_PRESENT;
        end
        S_PRESENT: begin
          if (accept) begin
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_HALT;
      endcase
    end

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // accepts are counted even when a halt or branch lands in the same cycle
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (accept && fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) fetch_count_q <= '0;
    else     fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
